// File: rtl/pipe_control_pkg.sv
// Shared opcode constants, ALU-op encodings and the pipeline control bundle.
// PIPE_CONTROL_JUMP_EN enables jump decoding in pipe_decode.
package pipe_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   regdst;
    logic   alusrc;
    aluop_e aluop;
    logic   branch;
    logic   memread;
    logic   memwrite;
    logic   regwrite;
    logic   memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'('0);

  // Instructions whose rt field is a source operand (load-use relevant).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational opcode decoder producing the pipeline control bundle.
// PIPE_CONTROL_JUMP_EN: opcode 000010 decodes as a jump instead of illegal.
module pipe_decode
  import pipe_control_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_jump
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b0;
    o_jump    = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.aluop    = ALUOP_FUNCT;
        o_ctrl.regwrite = 1'b1;
      end
      OP_LW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.aluop  = ALUOP_SUB;
      end
      OP_ADDI: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
`ifdef PIPE_CONTROL_JUMP_EN
      OP_J: o_jump = 1'b1;
`endif
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: decode staging, load-use stall, branch/jump flush, event counters.
// PIPE_CONTROL_JUMP_EN enables the jump flush path (see pipe_decode).
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_opcode,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             ex_zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ex_regdst,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             ex_taken,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_t             w_dec_ctrl;
  logic              w_dec_illegal;
  logic              w_jump;
  logic              w_hazard;
  logic              w_flush;
  logic              w_stall;
  logic              w_bubble;

  ctrl_t             r_idex;
  logic [AW-1:0]     r_idex_rt;
  logic              r_exmem_memread;
  logic              r_exmem_memwrite;
  logic              r_exmem_regwrite;
  logic              r_exmem_memtoreg;
  logic              r_memwb_regwrite;
  logic              r_memwb_memtoreg;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  pipe_decode u_decode (
    .i_opcode  (id_opcode),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal),
    .o_jump    (w_jump)
  );

  // A flush squashes the ID instruction anyway, so it overrides a stall.
  always_comb begin
    w_hazard = r_idex.memread &&
               ((r_idex_rt == id_rs) || ((r_idex_rt == id_rt) && reads_rt(id_opcode)));
    ex_taken = r_idex.branch & ex_zero;
    w_flush  = ex_taken | w_jump;
    w_stall  = w_hazard & ~w_flush;
    w_bubble = w_stall | w_flush;

    pc_write   = rst_n & ~w_stall;
    ifid_write = rst_n & ~w_stall;
    ifid_flush = rst_n & w_flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex           <= CTRL_NOP;
      r_idex_rt        <= '0;
      r_exmem_memread  <= 1'b0;
      r_exmem_memwrite <= 1'b0;
      r_exmem_regwrite <= 1'b0;
      r_exmem_memtoreg <= 1'b0;
      r_memwb_regwrite <= 1'b0;
      r_memwb_memtoreg <= 1'b0;
      r_illegal        <= 1'b0;
    end else begin
      r_idex           <= w_bubble ? CTRL_NOP : w_dec_ctrl;
      r_idex_rt        <= id_rt;
      r_exmem_memread  <= r_idex.memread;
      r_exmem_memwrite <= r_idex.memwrite;
      r_exmem_regwrite <= r_idex.regwrite;
      r_exmem_memtoreg <= r_idex.memtoreg;
      r_memwb_regwrite <= r_exmem_regwrite;
      r_memwb_memtoreg <= r_exmem_memtoreg;
      // A stalled illegal op is reported once, when it actually leaves ID.
      r_illegal        <= w_dec_illegal & ~w_bubble;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign ex_regdst    = r_idex.regdst;
  assign ex_alusrc    = r_idex.alusrc;
  assign ex_aluop     = r_idex.aluop;
  assign mem_memread  = r_exmem_memread;
  assign mem_memwrite = r_exmem_memwrite;
  assign wb_regwrite  = r_memwb_regwrite;
  assign wb_memtoreg  = r_memwb_memtoreg;
  assign illegal_op   = r_illegal;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control (CNT_W=2 so saturation is reachable).
// Honours PIPE_CONTROL_JUMP_EN to pick the expected jump behaviour.
module tb_pipe_control;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BAD  = 6'b111111;
  localparam logic [5:0] OPC_BAD2 = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       ex_zero;
  logic       pc_write, ifid_write, ifid_flush;
  logic       ex_regdst, ex_alusrc, ex_taken;
  logic [1:0] ex_aluop;
  logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, illegal_op;
  logic [1:0] stall_cnt, flush_cnt;

  pipe_control #(.AW(5), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_zero      (ex_zero),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .ex_regdst    (ex_regdst),
    .ex_alusrc    (ex_alusrc),
    .ex_aluop     (ex_aluop),
    .ex_taken     (ex_taken),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .illegal_op   (illegal_op),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [3:0] ex;   // {regdst, alusrc, aluop}
    logic [1:0] mem;  // {memread, memwrite}
    logic [1:0] wb;   // {regwrite, memtoreg}
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic       ill;
  } exp_t;

  localparam int NV = 10;
  vec_t tbl [NV];
  exp_t q_ex[$], q_mem[$], q_wb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    ex_zero = 1'b0;
    drive(OPC_R, 5'd0, 5'd0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] ex_bus();
    return {ex_regdst, ex_alusrc, ex_aluop};
  endfunction

  initial begin
    tbl[0] = '{OPC_R,    5'd1,  5'd2,  4'b1010, 2'b00, 2'b10, 1'b0};
    tbl[1] = '{OPC_LW,   5'd3,  5'd4,  4'b0100, 2'b10, 2'b11, 1'b0};
    tbl[2] = '{OPC_SW,   5'd5,  5'd6,  4'b0100, 2'b01, 2'b00, 1'b0};
    tbl[3] = '{OPC_BEQ,  5'd7,  5'd8,  4'b0001, 2'b00, 2'b00, 1'b0};
    tbl[4] = '{OPC_ADDI, 5'd9,  5'd10, 4'b0100, 2'b00, 2'b10, 1'b0};
    tbl[5] = '{OPC_BAD,  5'd1,  5'd2,  4'b0000, 2'b00, 2'b00, 1'b1};
    tbl[6] = '{OPC_LW,   5'd11, 5'd12, 4'b0100, 2'b10, 2'b11, 1'b0};
    tbl[7] = '{OPC_BAD2, 5'd13, 5'd14, 4'b0000, 2'b00, 2'b00, 1'b1};
    tbl[8] = '{OPC_R,    5'd0,  5'd0,  4'b1010, 2'b00, 2'b10, 1'b0};
    tbl[9] = '{OPC_R,    5'd0,  5'd0,  4'b1010, 2'b00, 2'b10, 1'b0};

    // Reset held for two cycles with lw in ID.
    rst_n   = 1'b0;
    ex_zero = 1'b0;
    drive(OPC_LW, 5'd5, 5'd5);
    tick();
    tick();
    chk("reset_outputs",
        {pc_write, ifid_write, ifid_flush, ex_bus(), ex_taken, mem_memread, mem_memwrite,
         wb_regwrite, wb_memtoreg, illegal_op}, 32'd0);
    chk("reset_counters", {stall_cnt, flush_cnt}, 32'd0);
    rst_n = 1'b1;
    drive(OPC_R, 5'd0, 5'd0);
    #1;
    chk("post_reset_pc_write", pc_write, 1'b1);

    // Decode and stage latency through the scoreboard.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].op, tbl[i].rs, tbl[i].rt);
      #1;
      chk("no_stall_no_flush", {pc_write, ifid_write, ifid_flush, ex_taken}, 4'b1100);
      q_ex.push_back('{tbl[i].ex, tbl[i].mem, tbl[i].wb, tbl[i].ill});
      tick();
      if (q_wb.size() > 0) begin
        e = q_wb.pop_front();
        chk("wb_ctrl", {wb_regwrite, wb_memtoreg}, e.wb);
      end
      if (q_mem.size() > 0) begin
        e = q_mem.pop_front();
        chk("mem_ctrl", {mem_memread, mem_memwrite}, e.mem);
        q_wb.push_back(e);
      end
      e = q_ex.pop_front();
      chk("ex_ctrl", ex_bus(), e.ex);
      chk("illegal_op", illegal_op, e.ill);
      q_mem.push_back(e);
    end
    chk("no_stall_count", stall_cnt, 2'd0);

    // Load-use: lw rt=5 then R-type rs=5.
    do_reset();
    drive(OPC_LW, 5'd0, 5'd5);
    tick();
    drive(OPC_R, 5'd5, 5'd1);
    #1;
    chk("lu_stall", {pc_write, ifid_write}, 2'b00);
    tick();
    chk("lu_bubble", ex_bus(), 4'b0000);
    chk("lu_stall_cnt", stall_cnt, 2'd1);
    chk("lu_stall_over", {pc_write, ifid_write}, 2'b11);
    tick();
    chk("lu_rtype_enters", ex_bus(), 4'b1010);
    chk("lu_stall_cnt_hold", stall_cnt, 2'd1);

    // Taken branch, then not-taken branch.
    do_reset();
    drive(OPC_BEQ, 5'd1, 5'd2);
    tick();
    drive(OPC_R, 5'd3, 5'd4);
    ex_zero = 1'b1;
    #1;
    chk("br_taken", {ex_taken, ifid_flush, pc_write}, 3'b111);
    tick();
    chk("br_bubble", ex_bus(), 4'b0000);
    chk("br_flush_cnt", flush_cnt, 2'd1);
    chk("br_flush_once", {ex_taken, ifid_flush}, 2'b00);
    drive(OPC_BEQ, 5'd1, 5'd2);
    ex_zero = 1'b0;
    tick();
    drive(OPC_R, 5'd3, 5'd4);
    #1;
    chk("br_not_taken", {ex_taken, ifid_flush, pc_write}, 3'b001);
    tick();
    chk("br_nt_flush_cnt", flush_cnt, 2'd1);
    chk("br_nt_no_bubble", ex_bus(), 4'b1010);

    // Jump and illegal opcodes.
    do_reset();
    drive(OPC_J, 5'd0, 5'd0);
    #1;
`ifdef PIPE_CONTROL_JUMP_EN
    chk("jump_flush", {ifid_flush, pc_write}, 2'b11);
    tick();
    chk("jump_no_illegal", illegal_op, 1'b0);
    chk("jump_flush_cnt", flush_cnt, 2'd1);
`else
    chk("jump_no_flush", ifid_flush, 1'b0);
    tick();
    chk("jump_illegal", illegal_op, 1'b1);
    chk("jump_flush_cnt", flush_cnt, 2'd0);
`endif
    chk("jump_zero_ctrl", ex_bus(), 4'b0000);
    drive(OPC_R, 5'd0, 5'd0);
    #1;
    chk("jump_flush_1cyc", ifid_flush, 1'b0);
    tick();
    chk("jump_ill_1cyc", illegal_op, 1'b0);
`ifdef PIPE_CONTROL_JUMP_EN
    // Jump in ID coinciding with a load-use hazard: flush wins.
    drive(OPC_LW, 5'd0, 5'd5);
    tick();
    drive(OPC_J, 5'd5, 5'd0);
    #1;
    chk("jump_vs_stall", {pc_write, ifid_flush}, 2'b11);
    tick();
    chk("jump_vs_stall_cnt", {stall_cnt, flush_cnt}, {2'd0, 2'd2});
`endif
    drive(OPC_BAD, 5'd0, 5'd0);
    tick();
    chk("bad_illegal", illegal_op, 1'b1);
    chk("bad_zero_ctrl", ex_bus(), 4'b0000);
    drive(OPC_R, 5'd0, 5'd0);
    tick();
    chk("bad_ill_1cyc", illegal_op, 1'b0);
    tick();
    chk("bad_zero_mem", {mem_memread, mem_memwrite}, 2'b00);

    // Reset during a stall and during a flush leaves no residue.
    do_reset();
    drive(OPC_LW, 5'd0, 5'd5);
    tick();
    drive(OPC_R, 5'd5, 5'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall_out", {pc_write, ifid_write, ifid_flush}, 3'b000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_stall_clear", {pc_write, ifid_write, stall_cnt}, {2'b11, 2'd0});
    drive(OPC_BEQ, 5'd1, 5'd2);
    tick();
    ex_zero = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rst_mid_flush_out", {pc_write, ifid_flush}, 2'b00);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_flush_clear", {ex_taken, ifid_flush, flush_cnt}, {2'b00, 2'd0});
    ex_zero = 1'b0;

    // Five consecutive load-use hazards saturate a 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(OPC_LW, 5'd0, 5'd5);
      tick();
      drive(OPC_R, 5'd5, 5'd0);
      tick();
      if (k == 2) chk("sat_cnt_at_3", stall_cnt, 2'd3);
    end
    chk("sat_stall_cnt", stall_cnt, 2'd3);
    chk("sat_flush_cnt", flush_cnt, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter AW, default 5: register-specifier width.
REQ-002 Parameter CNT_W, default 16: width of each performance counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_opcode  in  6  opcode of the instruction in the ID stage.
REQ-006 id_rs, id_rt  in  AW each  source specifiers of the ID-stage instruction.
REQ-007 ex_zero  in  1  ALU zero flag of the EX-stage instruction.
REQ-008 pc_write, ifid_write  out  1 each  PC and IF/ID register enables.
REQ-009 ifid_flush  out  1  replace the IF/ID instruction with a NOP.
REQ-010 ex_regdst, ex_alusrc  out  1 each; ex_aluop  out  2  EX-stage controls.
REQ-011 ex_taken  out  1  branch taken, resolved in EX.
REQ-012 mem_memread, mem_memwrite  out  1 each  MEM-stage controls.
REQ-013 wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls.
REQ-014 illegal_op  out  1  registered one-cycle pulse for an unrecognised opcode.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-016 Decode SHALL be: R-type 000000 {regdst=1, aluop=10, regwrite=1}; lw 100011 {alusrc, memread, memtoreg, regwrite, aluop=00}; sw 101011 {alusrc, memwrite, aluop=00}; beq 000100 {branch, aluop=01}; addi 001000 {alusrc, regwrite, aluop=00}. Unlisted bits are 0, never X.
REQ-017 Any other opcode SHALL decode to all-zero controls and pulse illegal_op in the following cycle.
REQ-018 Decoded controls SHALL be registered through ID/EX, EX/MEM and MEM/WB. ex_* appear 1 cycle after decode, mem_* 2 cycles after, wb_* 3 cycles after.
REQ-019 ID/EX SHALL also hold id_rt and the memread bit, for hazard detection.
REQ-020 Load-use stall: stall is asserted when ID/EX memread=1 and (idex_rt==id_rs, or idex_rt==id_rt with an opcode that reads rt: R-type, sw or beq).
REQ-021 During a stall: pc_write=0, ifid_write=0, and zeros are loaded into ID/EX controls (bubble). The stall lasts exactly 1 cycle per hazard.
REQ-022 ex_taken SHALL equal idex_branch AND ex_zero, combinationally.
REQ-023 When ex_taken=1: ifid_flush=1, a bubble is loaded into ID/EX, and pc_write=1.
REQ-024 If taken and stall conditions coincide, the flush SHALL win: no stall, the stall_cnt increment is suppressed, and the flush is counted.
REQ-025 stall_cnt SHALL increment once per stall cycle and flush_cnt once per flush cycle (including jump flushes). Both saturate at 2^CNT_W-1 with no wrap.
REQ-026 Outside stall and flush, pc_write=1, ifid_write=1 and ifid_flush=0.

Reset
REQ-027 While rst_n=0 at a clock edge, all pipeline control registers, illegal_op and both counters SHALL become 0.
REQ-028 While rst_n=0, pc_write=0, ifid_write=0 and ifid_flush=0. A reset asserted mid-stall or mid-flush abandons that stall or flush with no residue.

Configuration
REQ-029 With PIPE_CONTROL_JUMP_EN defined, opcode 000010 SHALL decode to all-zero pipeline controls and assert ifid_flush in the same cycle (1 bubble). It SHALL also increment flush_cnt.
REQ-030 Without PIPE_CONTROL_JUMP_EN, opcode 000010 SHALL be treated as illegal (REQ-017) and SHALL cause no flush.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the ALUOP encodings and the packed control-bundle typedef {regdst, alusrc, aluop, branch, memread, memwrite, regwrite, memtoreg}.
REQ-032 Decode SHALL be a purely combinational sub-module, pipe_decode. The hazard logic, stage registers and counters SHALL remain in pipe_control.

Verification
REQ-033 The bench SHALL cover reset: hold rst_n=0 for 2 cycles with opcode lw -> all outputs 0 and both counters 0; after release, pc_write=1.
REQ-034 The bench SHALL cover decode latency: R-type at cycle 0 -> ex_regdst=1 and ex_aluop=10 at cycle 1, wb_regwrite=1 at cycle 3, and no stall.
REQ-035 The bench SHALL cover load-use: lw with rt=5, then R-type with rs=5 -> 1 cycle with pc_write=0 and ifid_write=0, a bubble in EX next cycle, and stall_cnt=1.
REQ-036 The bench SHALL cover a taken branch: beq, then ex_zero=1 in its EX cycle -> ex_taken=1 and ifid_flush=1 for 1 cycle, and flush_cnt=1. With ex_zero=0 -> no flush.
REQ-037 The bench SHALL cover saturation: with CNT_W=2, 5 consecutive load-use hazards -> stall_cnt ends at 3.
REQ-038 The bench SHALL cover jump and illegal opcodes: opcode 000010 -> one-cycle ifid_flush when PIPE_CONTROL_JUMP_EN is defined, and an illegal_op pulse with no flush when it is not. Opcode 111111 -> illegal_op pulse and zero controls.
